wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage plus general-purpose register file for the 5-stage hazard-aware MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back value (load data or ALU result), and commits it to the 32×32 register file. Provides two combinational read ports to the ID stage with same-cycle write-to-read bypass, plus a registered commit trace and commit counter for debug and verification.

## Interface
Parameters:
- none; widths fixed (32-bit data, 5-bit register index, 32 registers).

Ports:
- Clk  input  1  pipeline clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
- wr_dout  input  32  load data from MEM/WB register.
- wr_alu_result  input  32  ALU result from MEM/WB register.
- wr_Rw  input  5  destination register index.
- wr_RegWr  input  1  write enable for this cycle's write-back.
- wr_MemtoReg  input  1  1 = write wr_dout, 0 = write wr_alu_result.
- Ra  input  5  ID read port A index.
- Rb  input  5  ID read port B index.
- busA  output  32  read data, port A (combinational).
- busB  output  32  read data, port B (combinational).
- busW  output  32  selected write-back value (combinational), exported for EX forwarding.
- wb_valid  output  1  registered: a commit occurred on the previous edge.
- wb_last_Rw  output  5  registered: index of last committed write.
- wb_last_data  output  32  registered: value of last committed write.
- wb_count  output  32  registered: number of commits since reset.

## Operation
- busW = wr_MemtoReg ? wr_dout : wr_alu_result, regardless of wr_RegWr.
- Commit condition: commit = wr_RegWr && (wr_Rw != 0) && !Reset.
- On posedge with commit: regs[wr_Rw] <= busW; wb_valid <= 1; wb_last_Rw <= wr_Rw; wb_last_data <= busW; wb_count <= wb_count + 1 (mod 2^32, wraps 0xFFFFFFFF -> 0).
- On posedge without commit: regs unchanged; wb_valid <= 0; wb_last_Rw, wb_last_data, wb_count hold.
- Writes to $0 with wr_RegWr=1: discarded, not counted, wb_valid=0. $0 always reads 0.
- Read port A: Ra==0 -> 0; else if commit && Ra==wr_Rw -> busW (bypass); else regs[Ra]. Port B identical with Rb.
- Both ports may read the same register simultaneously; both see the same (possibly bypassed) value.
- Reset (priority over everything): all 32 regs <= 0, wb_valid <= 0, wb_last_Rw <= 0, wb_last_data <= 0, wb_count <= 0. While Reset is high bypass is suppressed, so busA/busB return stored contents.
- Reset asserted mid-stream: the write-back present in the reset cycle is dropped (not written, not counted).
- No initial blocks relied on for functional state; reset is the only defined initialisation.

## Timing
- Write latency: value presented with commit in cycle N is stored at edge ending N; visible from regs in cycle N+1, and via bypass already in cycle N (zero-cycle write-to-read).
- Read ports and busW: purely combinational from current inputs and stored state; no added latency.
- Trace outputs (wb_valid, wb_last_Rw, wb_last_data, wb_count) update one edge after the commit cycle.
- Back-to-back commits to the same register: each edge overwrites; wb_count increments every cycle; wb_valid stays high.
- After Reset deasserts: first commit possible in that same cycle's edge.

## Test plan
- Reset: hold Reset 2 cycles after random writes -> all regs read 0 on both ports, wb_count=0, wb_valid=0, wb_last_Rw=0, wb_last_data=0.
- Mux + write: wr_Rw=5, RegWr=1, MemtoReg=1, wr_dout=0xDEADBEEF, alu=0x12345678 -> busW=0xDEADBEEF same cycle; next cycle Ra=5 reads 0xDEADBEEF, wb_valid=1, wb_last_Rw=5, wb_count=1. Repeat with MemtoReg=0 to reg 6 -> reg 6 = 0x12345678.
- Bypass: regs[7]=0x1; same cycle Ra=Rb=7 with commit of 0x55 to reg 7 -> busA=busB=0x55 before edge; RegWr=0 variant -> busA=0x1.
- $0 protection: RegWr=1, wr_Rw=0, busW=0xFFFFFFFF -> Ra=0 reads 0 that cycle and next, wb_count unchanged, wb_valid=0.
- Reset mid-write: Reset=1 with commit of 0xAA to reg 3 -> reg 3 reads 0 afterwards, wb_count=0.
- Counter wrap: 2^32 consecutive commits (or force wb_count=0xFFFFFFFF in simulation) then one commit -> wb_count=0, wb_valid=1.

Source files
------------

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Write-back stage and 32x32 general-purpose register file for the 5-stage
//   MIPS pipeline. It picks the write-back value (load data or ALU result) and
//   commits it to the register file. It also provides two combinational read
//   ports with a same-cycle write-to-read bypass, plus a registered commit trace.
//
// Ports
//   Clk            pipeline clock; all state changes on its rising edge
//   Reset          synchronous active-high reset
//   wr_dout        load data from the MEM/WB register
//   wr_alu_result  ALU result from the MEM/WB register
//   wr_Rw          destination register index
//   wr_RegWr       write enable for this cycle's write-back
//   wr_MemtoReg    1 selects wr_dout, 0 selects wr_alu_result
//   Ra, Rb         read port indices (ID stage)
//   busA, busB     read data (combinational, bypassed)
//   busW           selected write-back value (combinational)
//   wb_valid       a commit happened on the previous edge
//   wb_last_Rw     index of the last committed write
//   wb_last_data   value of the last committed write
//   wb_count       number of commits since reset (wraps modulo 2^32)
// -----------------------------------------------------------------------------
module wb_regfile (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] wr_dout,
    input  logic [31:0] wr_alu_result,
    input  logic [4:0]  wr_Rw,
    input  logic        wr_RegWr,
    input  logic        wr_MemtoReg,
    input  logic [4:0]  Ra,
    input  logic [4:0]  Rb,
    output logic [31:0] busA,
    output logic [31:0] busB,
    output logic [31:0] busW,
    output logic        wb_valid,
    output logic [4:0]  wb_last_Rw,
    output logic [31:0] wb_last_data,
    output logic [31:0] wb_count
);

    logic [31:0] regs_q [0:31];
    logic [31:0] regs_d [0:31];
    logic        wb_valid_q,     wb_valid_d;
    logic [4:0]  wb_last_rw_q,   wb_last_rw_d;
    logic [31:0] wb_last_data_q, wb_last_data_d;
    logic [31:0] wb_count_q,     wb_count_d;
    logic        commit_s;
    logic [31:0] busw_s;

    // Write-back value select and commit qualification.
    always_comb begin
        busw_s   = wr_MemtoReg ? wr_dout : wr_alu_result;
        // A write to $0 is not a commit. A write in a reset cycle is dropped.
        commit_s = wr_RegWr && (wr_Rw != 5'd0) && !Reset;
    end

    // Next-state computation for the register array and commit trace.
    always_comb begin
        regs_d         = regs_q;
        wb_valid_d     = 1'b0;
        wb_last_rw_d   = wb_last_rw_q;
        wb_last_data_d = wb_last_data_q;
        wb_count_d     = wb_count_q;
        if (commit_s) begin
            regs_d[wr_Rw]  = busw_s;
            wb_valid_d     = 1'b1;
            wb_last_rw_d   = wr_Rw;
            wb_last_data_d = busw_s;
            wb_count_d     = wb_count_q + 32'd1;
        end else begin
            wb_valid_d     = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            wb_valid_q     <= 1'b0;
            wb_last_rw_q   <= 5'd0;
            wb_last_data_q <= 32'd0;
            wb_count_q     <= 32'd0;
        end else begin
            regs_q         <= regs_d;
            wb_valid_q     <= wb_valid_d;
            wb_last_rw_q   <= wb_last_rw_d;
            wb_last_data_q <= wb_last_data_d;
            wb_count_q     <= wb_count_d;
        end
    end

    // Read ports. $0 is hard-wired to zero. A committing write to the same
    // index is forwarded in the same cycle. The bypass is suppressed during
    // Reset because commit_s is already low then.
    always_comb begin
        if (Ra == 5'd0) begin
            busA = 32'd0;
        end else if (commit_s && (Ra == wr_Rw)) begin
            busA = busw_s;
        end else begin
            busA = regs_q[Ra];
        end
        if (Rb == 5'd0) begin
            busB = 32'd0;
        end else if (commit_s && (Rb == wr_Rw)) begin
            busB = busw_s;
        end else begin
            busB = regs_q[Rb];
        end
    end

    assign busW         = busw_s;
    assign wb_valid     = wb_valid_q;
    assign wb_last_Rw   = wb_last_rw_q;
    assign wb_last_data = wb_last_data_q;
    assign wb_count     = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Self-checking bench for wb_regfile. A behavioural model of the register
//   file state is kept in plain arrays. A negedge process compares every DUT
//   output against it each cycle. Directed scenarios add literal expectations,
//   and a long randomized phase follows.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] wr_dout, wr_alu_result;
    logic [4:0]  wr_Rw;
    logic        wr_RegWr, wr_MemtoReg;
    logic [4:0]  Ra, Rb;
    logic [31:0] busA, busB, busW;
    logic        wb_valid;
    logic [4:0]  wb_last_Rw;
    logic [31:0] wb_last_data, wb_count;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference state
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [4:0]  m_last_rw;
    logic [31:0] m_last_data;
    logic [31:0] m_count;

    wb_regfile dut (
        .Clk(Clk), .Reset(Reset),
        .wr_dout(wr_dout), .wr_alu_result(wr_alu_result),
        .wr_Rw(wr_Rw), .wr_RegWr(wr_RegWr), .wr_MemtoReg(wr_MemtoReg),
        .Ra(Ra), .Rb(Rb),
        .busA(busA), .busB(busB), .busW(busW),
        .wb_valid(wb_valid), .wb_last_Rw(wb_last_Rw),
        .wb_last_data(wb_last_data), .wb_count(wb_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_busw();
        return wr_MemtoReg ? wr_dout : wr_alu_result;
    endfunction

    function automatic bit exp_commit();
        return (wr_RegWr === 1'b1) && (wr_Rw != 5'd0) && (Reset === 1'b0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (exp_commit() && idx == wr_Rw) return exp_busw();
        return m_regs[idx];
    endfunction

    // Model update at each rising edge
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_valid = 1'b0; m_last_rw = 5'd0; m_last_data = 32'd0; m_count = 32'd0;
        end else if (exp_commit()) begin
            m_regs[wr_Rw] = exp_busw();
            m_valid = 1'b1; m_last_rw = wr_Rw; m_last_data = exp_busw();
            m_count = m_count + 32'd1;
        end else begin
            m_valid = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge Clk) begin
        if (check_en) begin
            chk("busW", busW, exp_busw());
            chk("busA", busA, exp_read(Ra));
            chk("busB", busB, exp_read(Rb));
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
            chk("wb_last_Rw", {27'd0, wb_last_Rw}, {27'd0, m_last_rw});
            chk("wb_last_data", wb_last_data, m_last_data);
            chk("wb_count", wb_count, m_count);
        end
    end

    task automatic drive(input logic rst, input logic regwr, input logic m2r,
                         input logic [4:0] rw, input logic [31:0] dout,
                         input logic [31:0] alu, input logic [4:0] ra, input logic [4:0] rb);
        Reset = rst; wr_RegWr = regwr; wr_MemtoReg = m2r; wr_Rw = rw;
        wr_dout = dout; wr_alu_result = alu; Ra = ra; Rb = rb;
    endtask

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0; m_last_rw = 5'd0; m_last_data = 32'd0; m_count = 32'd0;

        // Random activity under reset, reset held for two cycles
        drive(1'b1, 1'b1, 1'b0, 5'd9, $urandom, $urandom, 5'd9, 5'd3);
        next_cycle();
        check_en = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd4, $urandom, $urandom, 5'd4, 5'd4);
        next_cycle();

        // Mux select and write to reg 5 (load data)
        drive(1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h12345678, 5'd5, 5'd0);
        #1;
        chk("lit_reset_count", wb_count, 32'd0);
        chk("lit_reset_valid", {31'd0, wb_valid}, 32'd0);
        chk("lit_busW_dout", busW, 32'hDEADBEEF);
        chk("lit_bypass5", busA, 32'hDEADBEEF);
        next_cycle();
        // ALU result write to reg 6
        drive(1'b0, 1'b1, 1'b0, 5'd6, 32'hDEADBEEF, 32'h12345678, 5'd5, 5'd6);
        #1;
        chk("lit_read5", busA, 32'hDEADBEEF);
        chk("lit_valid1", {31'd0, wb_valid}, 32'd1);
        chk("lit_last_rw5", {27'd0, wb_last_Rw}, 32'd5);
        chk("lit_count1", wb_count, 32'd1);
        chk("lit_busW_alu", busW, 32'h12345678);
        next_cycle();
        // Seed reg 7 = 1
        drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 32'h1, 5'd6, 5'd6);
        #1;
        chk("lit_read6", busA, 32'h12345678);
        chk("lit_count2", wb_count, 32'd2);
        next_cycle();
        // No-write variant: stored value seen
        drive(1'b0, 1'b0, 1'b0, 5'd7, 32'h0, 32'h55, 5'd7, 5'd7);
        #1;
        chk("lit_nobypass7", busA, 32'h1);
        next_cycle();
        // Bypass on both ports
        drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h0, 32'h55, 5'd7, 5'd7);
        #1;
        chk("lit_bypassA7", busA, 32'h55);
        chk("lit_bypassB7", busB, 32'h55);
        next_cycle();
        // Write to $0 is discarded
        drive(1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd7);
        #1;
        chk("lit_zero_same", busA, 32'd0);
        chk("lit_busW_ff", busW, 32'hFFFFFFFF);
        chk("lit_count4", wb_count, 32'd4);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 5'd3, 32'h0, 32'h77, 5'd0, 5'd7);
        #1;
        chk("lit_zero_next", busA, 32'd0);
        chk("lit_zero_valid", {31'd0, wb_valid}, 32'd0);
        chk("lit_zero_count", wb_count, 32'd4);
        next_cycle();
        // Reset with a commit pending: dropped, and no bypass during reset
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'hAA, 5'd3, 5'd3);
        #1;
        chk("lit_rst_nobypass", busA, 32'h77);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 5'd3, 32'h0, 32'h0, 5'd3, 5'd5);
        #1;
        chk("lit_rst_reg3", busA, 32'd0);
        chk("lit_rst_reg5", busB, 32'd0);
        chk("lit_rst_count", wb_count, 32'd0);
        next_cycle();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] rw;
            rw = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  1'($urandom), rw, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? rw : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? rw : 5'($urandom));
            next_cycle();
        end

        // Final reset held two cycles, then scan every register on both ports
        drive(1'b1, 1'b1, 1'b0, 5'd1, $urandom, $urandom, 5'd1, 5'd2);
        next_cycle();
        next_cycle();
        for (int r = 0; r < 32; r++) begin
            drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(r), 5'(31 - r));
            #1;
            chk("lit_scanA", busA, 32'd0);
            chk("lit_scanB", busB, 32'd0);
            next_cycle();
        end
        chk("lit_final_count", wb_count, 32'd0);
        chk("lit_final_last", wb_last_data, 32'd0);

        @(negedge Clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
